// File: rtl/port_allocator.sv
// Wormhole output-port allocator: round-robin arbitration among REN inputs,
// packet-granular ownership and credit-based flow control toward downstream.
module port_allocator #(
  parameter int REN     = 5,
  parameter int PL      = 32,
  parameter int CREDITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REN*PL-1:0]             in_flit,
  input  logic [REN-1:0]                in_tail,
  output logic [REN-1:0]                in_pop,
  output logic [PL-1:0]                 out_flit,
  output logic                          out_valid,
  input  logic                          credit_ret,
  output logic [((REN > 1) ? $clog2(REN) : 1)-1:0] owner,
  output logic                          busy,
  output logic                          credit_err
);

  localparam int OW = (REN > 1) ? $clog2(REN) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   ptr_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [CW-1:0]   cnt;
  logic [REN-1:0]  req;
  logic [2*REN-1:0] req_dbl;
  logic [REN-1:0]  req_rot;
  logic [OW-1:0]   grant_idx;
  logic [PL-1:0]   owner_flit;
  logic            owner_tail;
  logic            xfer;
  logic            err_set;

  // Reduce an index in [0, 2*REN) back into [0, REN).
  function automatic logic [OW-1:0] wrap_idx(input int v);
    int r;
    r = (v >= REN) ? v - REN : v;
    return OW'(r);
  endfunction

  // Credit counter update; a simultaneous take and give cancel out, and a
  // give at full capacity saturates instead of wrapping.
  function automatic logic [CW-1:0] cnt_update(input logic [CW-1:0] c,
                                               input logic          take,
                                               input logic          give);
    logic [CW-1:0] r;
    case ({take, give})
      2'b10:   r = c - CW'(1);
      2'b01:   r = (c == CW'(CREDITS)) ? c : c + CW'(1);
      default: r = c;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < REN; g++) begin : g_req
    assign req[g] = in_flit[g*PL];
  end

  // Rotate the request vector so bit 0 corresponds to the pointer position;
  // the lowest set bit of the rotated vector is the round-robin winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[int'(ptr) +: REN];

  always_comb begin
    grant_idx = '0;
    for (int j = REN - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        grant_idx = wrap_idx(int'(ptr) + j);
      end
    end
  end

  always_comb begin
    owner_flit = '0;
    owner_tail = 1'b0;
    for (int i = 0; i < REN; i++) begin
      if (owner == OW'(i)) begin
        owner_flit = in_flit[i*PL +: PL];
        owner_tail = in_tail[i];
      end
    end
  end

  // A transfer needs the owner's head flit valid and at least one credit.
  assign xfer    = (state == BUSY) && owner_flit[0] && (cnt != '0) && !rst;
  assign err_set = credit_ret && !xfer && (cnt == CW'(CREDITS));
  assign busy    = (state == BUSY);

  always_comb begin
    in_pop = '0;
    if (xfer) begin
      in_pop = REN'(1) << owner;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BUSY;
          owner_nxt = grant_idx;
          ptr_nxt   = wrap_idx(int'(grant_idx) + 1);
        end
      end
      BUSY: begin
        if (xfer && owner_tail) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Output stage: flit register plus credit bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= CW'(CREDITS);
      credit_err <= 1'b0;
      out_valid  <= 1'b0;
      out_flit   <= '0;
    end else begin
      cnt        <= cnt_update(cnt, xfer, credit_ret);
      credit_err <= credit_err | err_set;
      out_valid  <= xfer;
      if (xfer) begin
        out_flit <= owner_flit;
      end
    end
  end

endmodule

// File: tb/tb_port_allocator.sv
// Self-checking bench for port_allocator: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_port_allocator;
  localparam int REN     = 5;
  localparam int PL      = 32;
  localparam int CREDITS = 4;
  localparam int OW      = $clog2(REN);

  logic              clk = 1'b0;
  logic              rst;
  logic [REN*PL-1:0] in_flit;
  logic [REN-1:0]    in_tail;
  logic [REN-1:0]    in_pop;
  logic [PL-1:0]     out_flit;
  logic              out_valid;
  logic              credit_ret;
  logic [OW-1:0]     owner;
  logic              busy;
  logic              credit_err;

  int total = 0;
  int bad   = 0;

  logic [PL-1:0]  f [REN];
  logic [REN-1:0] t;
  logic           cr;

  logic          m_busy, m_ov, m_err;
  int            m_ptr, m_owner, m_cnt;
  logic [PL-1:0] m_flit;
  logic          n_busy, n_ov, n_err;
  int            n_ptr, n_owner, n_cnt;
  logic [PL-1:0] n_flit;
  logic [REN-1:0] exp_pop, obs_pop;

  always #5 clk = ~clk;

  port_allocator #(.REN(REN), .PL(PL), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_tail(in_tail), .in_pop(in_pop),
    .out_flit(out_flit), .out_valid(out_valid), .credit_ret(credit_ret),
    .owner(owner), .busy(busy), .credit_err(credit_err)
  );

  function automatic logic [PL-1:0] rnd_flit(input logic v);
    logic [PL-1:0] x;
    x = PL'($urandom);
    x[0] = v;
    return x;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < REN; i++) f[i] = '0;
    t  = '0;
    cr = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < REN; i++) in_flit[i*PL +: PL] = f[i];
    in_tail    = t;
    credit_ret = cr;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ov = 1'b0; m_err = 1'b0;
    m_ptr = 0; m_owner = 0; m_cnt = CREDITS; m_flit = '0;
  endtask

  // Next-state of the model from the protocol rules, for the current inputs.
  task automatic model_eval();
    int   sel;
    logic x;
    n_busy = m_busy; n_ptr = m_ptr; n_owner = m_owner; n_cnt = m_cnt;
    n_err = m_err; n_flit = m_flit;
    exp_pop = '0; x = 1'b0; sel = -1;
    if (!m_busy) begin
      for (int k = 0; k < REN; k++)
        if (sel < 0 && f[(m_ptr + k) % REN][0]) sel = (m_ptr + k) % REN;
      if (sel >= 0) begin
        n_busy = 1'b1; n_owner = sel; n_ptr = (sel + 1) % REN;
      end
    end else if (f[m_owner][0] && m_cnt > 0) begin
      x = 1'b1;
      exp_pop[m_owner] = 1'b1;
      n_flit = f[m_owner];
      if (t[m_owner]) n_busy = 1'b0;
    end
    n_ov = x;
    if (x && !cr) n_cnt = m_cnt - 1;
    else if (!x && cr) begin
      if (m_cnt == CREDITS) n_err = 1'b1;
      else n_cnt = m_cnt + 1;
    end
  endtask

  // One clock: drive at negedge, capture in_pop, advance model at posedge.
  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    model_eval();
    obs_pop = in_pop;
    @(posedge clk);
    m_busy = n_busy; m_ptr = n_ptr; m_owner = n_owner; m_cnt = n_cnt;
    m_ov = n_ov; m_err = n_err; m_flit = n_flit;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    drive();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    f[1] = rnd_flit(1'b1); f[3] = rnd_flit(1'b1);
    drive();
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({in_pop, busy, owner, out_valid, credit_err, out_flit} !== '0) begin
      bad++;
      $display("FAIL reset_values: got pop=%b busy=%b owner=%0d ov=%b err=%b flit=%h want all zero",
               in_pop, busy, owner, out_valid, credit_err, out_flit);
    end
    @(posedge clk); #1;
    total++;
    if (in_pop !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got pop=%b busy=%b want 0 0", in_pop, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || owner !== OW'(1) || obs_pop !== '0) begin
      bad++;
      $display("FAIL reset_first_grant: got busy=%b owner=%0d pop=%b want 1 1 00000", busy, owner, obs_pop);
    end
  endtask

  task automatic test_single();
    logic [PL-1:0] fl;
    apply_reset();
    fl = rnd_flit(1'b1);
    f[2] = fl; t[2] = 1'b1;
    tick();
    total++;
    if (obs_pop !== 5'b00000 || busy !== 1'b1 || owner !== OW'(2)) begin
      bad++;
      $display("FAIL single_arb: got pop=%b busy=%b owner=%0d want 00000 1 2", obs_pop, busy, owner);
    end
    tick();
    total++;
    if (obs_pop !== 5'b00100 || out_valid !== 1'b1 || busy !== 1'b0 || out_flit !== fl) begin
      bad++;
      $display("FAIL single_pop: got pop=%b ov=%b busy=%b flit=%h want 00100 1 0 %h",
               obs_pop, out_valid, busy, out_flit, fl);
    end
    clear_inputs();
    tick();
    total++;
    if (out_valid !== 1'b0 || out_flit !== fl || {busy, owner, out_valid, credit_err, out_flit} !==
        {m_busy, OW'(m_owner), m_ov, m_err, m_flit}) begin
      bad++;
      $display("FAIL single_hold: got ov=%b flit=%h want 0 %h", out_valid, out_flit, fl);
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < REN; i++) f[i] = rnd_flit(1'b1);
      t = '1;
      tick();
      total++;
      if (obs_pop !== exp_pop) begin
        bad++;
        $display("FAIL rr_pop c%0d: got %b want %b", c, obs_pop, exp_pop);
      end
      for (int i = 0; i < REN; i++) if (obs_pop[i]) got.push_back(i);
      cr = |obs_pop;
    end
    cr = 1'b0;
    total++;
    if (got.size() != 6) begin
      bad++;
      $display("FAIL rr_count: got %0d grants want 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (got[k] != exp_order[k]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", k, got[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_wormhole();
    int v0[7] = '{0, 1, 1, 1, 1, 1, 1};
    int v1[7] = '{1, 1, 0, 1, 1, 0, 0};
    int t1[7] = '{0, 0, 0, 0, 1, 0, 0};
    int exp_seq[4] = '{1, 1, 1, 0};
    int got[$];
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      f[0] = rnd_flit(v0[c] != 0);
      f[1] = rnd_flit(v1[c] != 0);
      t = {3'b000, t1[c] != 0, 1'b1};
      tick();
      total++;
      if (obs_pop !== exp_pop ||
          {busy, owner, out_valid, credit_err, out_flit} !== {m_busy, OW'(m_owner), m_ov, m_err, m_flit}) begin
        bad++;
        $display("FAIL worm_c%0d: got pop=%b owner=%0d busy=%b want pop=%b owner=%0d busy=%b",
                 c, obs_pop, owner, busy, exp_pop, m_owner, m_busy);
      end
      for (int i = 0; i < REN; i++) if (obs_pop[i]) got.push_back(i);
    end
    total++;
    if (got.size() != 4 || got[0] != exp_seq[0] || got[1] != exp_seq[1] ||
        got[2] != exp_seq[2] || got[3] != exp_seq[3]) begin
      bad++;
      $display("FAIL worm_seq: got %p want %p", got, exp_seq);
    end
  endtask

  task automatic test_credit_stall();
    int n = 0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      f[3] = rnd_flit(1'b1);
      t[3] = (n == 5);
      tick();
      if (obs_pop[3]) n++;
    end
    total++;
    if (n != 4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL credit_stall: got pops=%0d busy=%b want 4 1", n, busy);
    end
    cr = 1'b1;
    tick();
    if (obs_pop[3]) n++;
    cr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      f[3] = rnd_flit(1'b1);
      t[3] = (n == 5);
      tick();
      if (obs_pop[3]) n++;
    end
    total++;
    if (n != 5 || busy !== m_busy || out_flit !== m_flit) begin
      bad++;
      $display("FAIL credit_one_more: got pops=%0d busy=%b want 5 %b", n, busy, m_busy);
    end
  endtask

  task automatic test_credit_err();
    apply_reset();
    cr = 1'b1;
    tick();
    cr = 1'b0;
    total++;
    if (credit_err !== 1'b1) begin
      bad++;
      $display("FAIL credit_err_set: got %b want 1", credit_err);
    end
    f[0] = rnd_flit(1'b1); t[0] = 1'b1;
    repeat (2) tick();
    clear_inputs();
    repeat (2) tick();
    total++;
    if (credit_err !== 1'b1 || out_flit !== m_flit) begin
      bad++;
      $display("FAIL credit_err_sticky: got %b want 1", credit_err);
    end
    apply_reset();
    total++;
    if (credit_err !== 1'b0) begin
      bad++;
      $display("FAIL credit_err_clear: got %b want 0", credit_err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    f[2] = rnd_flit(1'b1);
    repeat (2) tick();
    @(negedge clk);
    f[1] = rnd_flit(1'b1); f[2] = rnd_flit(1'b1); f[4] = rnd_flit(1'b1);
    drive();
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_pop !== '0 || owner !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b ov=%b pop=%b owner=%0d want 0 0 00000 0",
               busy, out_valid, in_pop, owner);
    end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || owner !== OW'(1)) begin
      bad++;
      $display("FAIL reset_mid_regrant: got busy=%b owner=%0d want 1 1", busy, owner);
    end
    for (int c = 0; c < 6; c++) begin
      f[1] = rnd_flit(1'b1);
      tick();
      if (obs_pop[1]) n++;
    end
    total++;
    if (n != CREDITS) begin
      bad++;
      $display("FAIL reset_mid_credits: got pops=%0d want %0d", n, CREDITS);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REN; i++) f[i] = rnd_flit($urandom_range(0, 99) < 40);
      t  = REN'($urandom);
      cr = ($urandom_range(0, 3) == 0);
      tick();
      total++;
      if (obs_pop !== exp_pop || !$onehot0(obs_pop)) begin
        bad++;
        $display("FAIL rand_pop c%0d: got %b want %b", c, obs_pop, exp_pop);
      end
      total++;
      if ({busy, owner, out_valid, credit_err, out_flit} !== {m_busy, OW'(m_owner), m_ov, m_err, m_flit}) begin
        bad++;
        $display("FAIL rand_out c%0d: got busy=%b owner=%0d ov=%b err=%b flit=%h want %b %0d %b %b %h",
                 c, busy, owner, out_valid, credit_err, out_flit, m_busy, m_owner, m_ov, m_err, m_flit);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    drive();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 Parameter REN, default 5: number of requesting input ports.
REQ-002 Parameter PL, default 32: flit width in bits; bit 0 is the valid flag.
REQ-003 Parameter CREDITS, default 4: downstream buffer depth in flits; CW = clog2(CREDITS+1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_flit  input  REN x PL  head-of-queue flit per input; in_flit[i][0] is request/valid.
REQ-008 in_tail  input  REN  in_tail[i]=1 marks in_flit[i] as the last flit of its packet.
REQ-009 in_pop  output  REN  one-hot, combinational; in_pop[i]=1 consumes in_flit[i] this cycle.
REQ-010 out_flit  output  PL  registered flit to downstream.
REQ-011 out_valid  output  1  registered; out_flit is valid this cycle.
REQ-012 credit_ret  input  1  one-cycle pulse; downstream freed one slot.
REQ-013 owner  output  clog2(REN)  index of the input currently holding the port.
REQ-014 busy  output  1  1 while in state BUSY.
REQ-015 credit_err  output  1  sticky credit-overflow flag.

Function
REQ-016 States: IDLE, BUSY; internal registers ptr (round-robin pointer, clog2(REN) bits) and cnt (CW bits).
REQ-017 IDLE: if any in_flit[i][0]=1, select the first i with valid set, scanning ptr, ptr+1, ..., wrapping modulo REN.
REQ-018 On selection: owner<=i, ptr<=(i+1) mod REN, state<=BUSY; no pop in this cycle (1-cycle arbitration latency).
REQ-019 IDLE with no request: all registers hold, in_pop=0.
REQ-020 BUSY: transfer occurs when in_flit[owner][0]=1 and cnt>0; then in_pop[owner]=1, out_flit<=in_flit[owner], out_valid<=1 on the next edge.
REQ-021 No transfer in a cycle: in_pop=0, out_valid<=0, out_flit holds its previous value.
REQ-022 Transfer with in_tail[owner]=1: state<=IDLE next edge; single-flit packets (head is tail) are legal.
REQ-023 Owner valid low mid-packet, or cnt=0: remain BUSY, owner locked, other inputs are never granted (wormhole hold).
REQ-024 Requests from non-owner inputs while BUSY SHALL be ignored and SHALL not alter ptr.
REQ-025 cnt: -1 on transfer, +1 on credit_ret, unchanged if both occur in the same cycle.
REQ-026 credit_ret with cnt=CREDITS and no transfer: cnt holds, credit_err<=1; credit_err clears only on reset.
REQ-027 cnt SHALL never underflow; transfers are blocked at cnt=0 (REQ-020).
REQ-028 Round-robin fairness: an input with a continuous request is granted within REN-1 intervening packets.
REQ-029 in_pop SHALL be all-zero in IDLE and at most one-hot in BUSY.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, ptr=0, owner=0, cnt=CREDITS, out_valid=0, out_flit=0, credit_err=0.
REQ-031 Reset mid-packet: packet is abandoned, no further pops; after release arbitration restarts from ptr=0.
REQ-032 in_pop SHALL be 0 while rst=1.

Verification
REQ-033 Single request: in_flit[2] valid, tail=1 -> cycle1 owner=2, busy=1; cycle2 in_pop[2]=1; cycle3 out_valid=1, busy=0, ptr=3, cnt=3.
REQ-034 All five inputs requesting 1-flit packets continuously -> grant order 0,1,2,3,4,0; no input granted twice before others.
REQ-035 3-flit packet on input 1, input 0 also requesting -> three consecutive pops on input 1, then input 0 granted next; no interleaving.
REQ-036 CREDITS=4, no credit_ret, 6-flit packet -> exactly 4 pops, stall at cnt=0; one credit_ret pulse -> exactly one more pop.
REQ-037 credit_ret at cnt=4 with no transfer -> cnt stays 4, credit_err=1 until rst.
REQ-038 rst asserted during flit 2 of a 4-flit packet -> immediately busy=0, out_valid=0, cnt=4; after release, lowest-index requester from 0 is granted.
